// File: rtl/pcie_comma_align.sv
// pcie_comma_align: finds K28.5 commas in a raw 10-bit word stream and
// barrel-shifts it so every output word is one whole 10b symbol.
// A hunt/verify/lock FSM adds hysteresis against stray or corrupt commas.
// Build option: define PCIE_COMMA_BOTH_RD_EN to also accept RD+ K28.5.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset
//   RAW_D   - raw deserialized word, bit 9 received first
//   HSS_TXD - registered aligned symbol (a..j, a in bit 9)
//   ALIGNED - high while locked
//   SHIFT   - applied bit offset, 0..9
module pcie_comma_align #(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] RAW_D,
    output logic [9:0] HSS_TXD,
    output logic       ALIGNED,
    output logic [3:0] SHIFT
);

    localparam logic [9:0] K28_5_N  = 10'b0011111010;
    localparam logic [9:0] K28_5_P  = 10'b1100000101;
    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [3:0]  cnt;
    logic [3:0]  cnt_n;
    logic [3:0]  shift_n;
    logic [9:0]  prev;
    logic [19:0] win;
    logic [9:0]  cand [10];
    logic [9:0]  hit;
    logic [3:0]  first_k;
    logic        any_hit;
    logic        cur_hit;

    // Two-word window; candidate k starts k bits into the older word.
    assign win = {prev, RAW_D};

    always_comb begin
        hit = '0;
        for (int k = 0; k < 10; k++) begin
            cand[k] = 10'(win >> (10 - k));
`ifdef PCIE_COMMA_BOTH_RD_EN
            hit[k] = (cand[k] == K28_5_N) || (cand[k] == K28_5_P);
`else
            hit[k] = (cand[k] == K28_5_N);
`endif
        end
    end

    // Lowest matching offset wins.
    always_comb begin
        first_k = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (hit[k]) first_k = 4'(k);
        end
    end

    assign any_hit = |hit;
    assign cur_hit = hit[SHIFT];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = SHIFT;
        unique case (state)
            HUNT: begin
                if (any_hit) begin
                    shift_n = first_k;
                    cnt_n   = 4'd0;
                    state_n = VERIFY;
                end
            end
            VERIFY: begin
                if (cur_hit) begin
                    if (cnt + 4'd1 == LOCK_N) begin
                        cnt_n   = 4'd0;
                        state_n = LOCKED;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end else if (any_hit) begin
                    shift_n = first_k;
                    cnt_n   = 4'd0;
                end
            end
            LOCKED: begin
                // A comma at the locked offset clears the miss count even
                // when other offsets also match.
                if (cur_hit) begin
                    cnt_n = 4'd0;
                end else if (any_hit) begin
                    if (cnt + 4'd1 == UNLOCK_N) begin
                        cnt_n   = 4'd0;
                        state_n = HUNT;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_n = HUNT;
                cnt_n   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HUNT;
            cnt     <= 4'd0;
            SHIFT   <= 4'd0;
            prev    <= 10'd0;
            HSS_TXD <= 10'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            SHIFT   <= shift_n;
            prev    <= RAW_D;
            // Output uses the offset held before this edge.
            HSS_TXD <= cand[SHIFT];
        end
    end

    assign ALIGNED = (state == LOCKED);

endmodule

// File: tb/tb_pcie_comma_align.sv
// tb_pcie_comma_align: directed vector table plus hand-written sequences
// for pcie_comma_align (lock, restart, unlock, polarity, reset).
module tb_pcie_comma_align;

    localparam logic [9:0] CN = 10'b0011111010;
    localparam logic [9:0] CP = 10'b1100000101;
    localparam logic [9:0] DD = 10'b1010101010;
    localparam logic [9:0] W0 = 10'b1010011111;
    localparam logic [9:0] WA = 10'b0100011111;
    localparam logic [9:0] WB = 10'b0101010101;

    typedef struct {
        logic [9:0] raw;
        logic [9:0] txd;
        logic       al;
        logic [3:0] sh;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] raw = 10'd0;
    logic [9:0] txd;
    logic       al;
    logic [3:0] sh;

    int n_vec = 0;
    int n_bad = 0;
    int pushed = 0;
    logic bq[$];
    vec_t tbl[10];

    always #5 clk = ~clk;

    pcie_comma_align dut (
        .clk    (clk),
        .rst    (rst),
        .RAW_D  (raw),
        .HSS_TXD(txd),
        .ALIGNED(al),
        .SHIFT  (sh)
    );

    task automatic chk(input string name, input logic [9:0] act,
                       input logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic [9:0] w);
        raw = w;
        @(posedge clk);
        #1;
    endtask

    task automatic push_sym(input logic [9:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bq.push_back(v[9-i]);
            pushed++;
        end
    endtask

    task automatic drain();
        logic [9:0] w;
        while (bq.size() >= 10) begin
            for (int i = 0; i < 10; i++) w[9-i] = bq.pop_front();
            step(w);
        end
    endtask

    // Places sym at bit offset k, follows it with a data symbol and
    // clocks every complete word, so the comma is fully seen on return.
    task automatic send(input logic [9:0] sym, input int k);
        int pad;
        pad = (k - (pushed % 10) + 10) % 10;
        push_sym(DD, pad);
        push_sym(sym, 10);
        push_sym(DD, 10);
        drain();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(10'($urandom));
        step(10'($urandom));
        rst = 1'b0;
        bq.delete();
        pushed = 0;
    endtask

    initial begin
        tbl[0] = '{W0, 10'd0, 1'b0, 4'd0};
        tbl[1] = '{WB, W0,    1'b0, 4'd3};
        tbl[2] = '{WA, DD,    1'b0, 4'd3};
        tbl[3] = '{WB, CN,    1'b0, 4'd3};
        tbl[4] = '{WA, DD,    1'b0, 4'd3};
        tbl[5] = '{WB, CN,    1'b0, 4'd3};
        tbl[6] = '{WA, DD,    1'b0, 4'd3};
        tbl[7] = '{WB, CN,    1'b1, 4'd3};
        tbl[8] = '{WA, DD,    1'b1, 4'd3};
        tbl[9] = '{WB, CN,    1'b1, 4'd3};

        // Reset behaviour
        rst = 1'b1;
        step(10'($urandom));
        step(10'($urandom));
        chk("rst_txd", txd, 10'd0);
        chk("rst_al", 10'(al), 10'd0);
        chk("rst_sh", 10'(sh), 10'd0);

        // Lock at offset 3, cycle by cycle
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].raw);
            chk($sformatf("tbl%0d_txd", i), txd, tbl[i].txd);
            chk($sformatf("tbl%0d_al", i), 10'(al), 10'(tbl[i].al));
            chk($sformatf("tbl%0d_sh", i), 10'(sh), 10'(tbl[i].sh));
        end

        // Restart in VERIFY
        do_reset();
        send(CN, 3);
        chk("rv_sh3", 10'(sh), 10'd3);
        chk("rv_al_a", 10'(al), 10'd0);
        send(CN, 3);
        send(CN, 3);
        chk("rv_al_b", 10'(al), 10'd0);
        send(CN, 7);
        chk("rv_sh7", 10'(sh), 10'd7);
        chk("rv_al_c", 10'(al), 10'd0);
        send(CN, 7);
        send(CN, 7);
        chk("rv_al_d", 10'(al), 10'd0);
        send(CN, 7);
        chk("rv_al_lock", 10'(al), 10'd1);
        chk("rv_sh_lock", 10'(sh), 10'd7);

        // Unlock hysteresis
        do_reset();
        for (int i = 0; i < 4; i++) send(CN, 3);
        chk("ul_lock", 10'(al), 10'd1);
        for (int i = 0; i < 3; i++) begin
            send(CN, 5);
            chk($sformatf("ul_miss%0d", i), 10'(al), 10'd1);
        end
        send(CN, 3);
        chk("ul_clear", 10'(al), 10'd1);
        for (int i = 0; i < 3; i++) begin
            send(CN, 5);
            chk($sformatf("ul_hold%0d", i), 10'(al), 10'd1);
        end
        send(CN, 5);
        chk("ul_drop", 10'(al), 10'd0);
        chk("ul_sh_hold", 10'(sh), 10'd3);
        send(CN, 5);
        chk("ul_rehunt_sh", 10'(sh), 10'd5);
        chk("ul_rehunt_al", 10'(al), 10'd0);

        // Polarity handling
        do_reset();
        for (int i = 0; i < 3; i++) send(CP, 0);
        chk("rdp_al_early", 10'(al), 10'd0);
        send(CP, 0);
`ifdef PCIE_COMMA_BOTH_RD_EN
        chk("rdp_al", 10'(al), 10'd1);
`else
        chk("rdp_al", 10'(al), 10'd0);
`endif
        chk("rdp_sh", 10'(sh), 10'd0);

        // Synchronous reset mid-lock
        do_reset();
        for (int i = 0; i < 4; i++) send(CN, 3);
        chk("ml_lock", 10'(al), 10'd1);
        rst = 1'b1;
        step(10'($urandom));
        chk("ml_rst_al", 10'(al), 10'd0);
        chk("ml_rst_sh", 10'(sh), 10'd0);
        chk("ml_rst_txd", txd, 10'd0);
        rst = 1'b0;
        bq.delete();
        pushed = 0;
        for (int i = 0; i < 3; i++) send(CN, 3);
        chk("ml_relock_early", 10'(al), 10'd0);
        send(CN, 3);
        chk("ml_relock", 10'(al), 10'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pcie_comma_align.md
# pcie_comma_align

Symbol aligner directly upstream of the 8b/10b decode stage. Takes a raw 10-bit parallel word stream of arbitrary bit alignment, finds K28.5 commas, and barrel-shifts the stream so each output word is one whole 10b symbol on `HSS_TXD`, ready for the decoder. A hunt/verify/lock state machine provides hysteresis, so a single corrupted or spurious comma does not move the alignment.

## Interface
- `LOCK_CNT`, default 3: further commas at the candidate offset needed in VERIFY before declaring lock (range 1..15).
- `UNLOCK_CNT`, default 4: consecutive misaligned commas in LOCKED that force a return to HUNT (range 1..15).
- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `RAW_D` input, 10 bits: raw deserialized word, one per cycle. Bit 9 is the earliest received bit.
- `HSS_TXD` output, 10 bits: aligned symbol, bit order a..j with a in bit 9. Feeds the decoder input.
- `ALIGNED` output, 1 bit: high while in LOCKED.
- `SHIFT` output, 4 bits: currently applied offset, 0..9.

## Operation
- **Window.** W[19:0] = {prev, RAW_D}, where prev is RAW_D registered from the previous cycle. The candidate at offset k is W[19-k:10-k], for k = 0..9.
- **Comma match.** A candidate is a comma when it equals 10'b0011111010 (K28.5, RD-). With the macro in Configuration, 10'b1100000101 (RD+) also matches. If several offsets match, the lowest k is the detected offset.
- **States:** HUNT, VERIFY, LOCKED. A 4-bit count register `cnt` supports VERIFY and LOCKED.
- **HUNT:**
  - On any comma: SHIFT <= k, cnt <= 0, go to VERIFY.
  - Otherwise stay in HUNT; SHIFT holds.
- **VERIFY:**
  - Comma at offset == SHIFT: cnt+1. When cnt+1 == LOCK_CNT, go to LOCKED with cnt <= 0.
  - Comma only at another offset: SHIFT <= new k, cnt <= 0, stay in VERIFY.
  - No comma: hold.
- **LOCKED:**
  - Any comma at offset == SHIFT, even if other offsets also match: cnt <= 0.
  - Comma only at other offsets: cnt+1. When cnt+1 == UNLOCK_CNT, go to HUNT with cnt <= 0; SHIFT holds until the next HUNT detection.
  - No comma: hold.
- **Output.** HSS_TXD is always the candidate at the current SHIFT, registered. It is driven in every state; the downstream block qualifies it with ALIGNED.
- **Reset.** HSS_TXD = 0, prev = 0, ALIGNED = 0, SHIFT = 0, cnt = 0, state = HUNT. Reset mid-lock drops ALIGNED on the next edge.

## Timing
- **Pipeline:** one register stage. A symbol whose last bit arrives in RAW_D at cycle n appears on HSS_TXD at cycle n+1.
- **Offset update:** the selection uses the SHIFT value registered before the edge. A SHIFT change made at edge n takes effect on HSS_TXD from edge n+1.
- **ALIGNED:** rises on the edge that enters LOCKED and falls on the edge that enters HUNT.
- **Minimum lock time:** from the first comma, LOCK_CNT+1 comma-bearing cycles.
- **Comma spacing:** no requirement. Commas in back-to-back cycles are each counted.

## Configuration
- `PCIE_COMMA_BOTH_RD_EN`
  - Defined: both K28.5 disparities (RD- and RD+) are recognised as commas.
  - Undefined: only the RD- pattern 10'b0011111010 is recognised; RD+ commas are treated as data.

## Test plan
- **Reset behaviour:** rst high for 2 cycles with random RAW_D -> HSS_TXD = 0, ALIGNED = 0, SHIFT = 0.
- **Lock at offset 3:** stream of K28.5 (RD-) at bit offset 3, interleaved with D-symbols, 4 commas -> SHIFT = 3 after the first comma; ALIGNED rises on the edge of the 4th comma; subsequent HSS_TXD shows whole symbols, e.g. 10'b0011111010 one cycle after each comma completes.
- **Restart in VERIFY:** lock attempt at offset 3, then a comma at offset 7 after 2 good commas -> SHIFT = 7, ALIGNED stays 0; 3 more commas at offset 7 -> ALIGNED = 1.
- **Unlock hysteresis:** while locked at offset 3, inject 3 commas at offset 5, then 1 at offset 3, then 4 at offset 5 -> ALIGNED stays 1 through the first 3 (the offset-3 comma clears cnt); drops on the 4th consecutive offset-5 comma; next comma sets SHIFT = 5.
- **Polarity handling:** RD+ commas (10'b1100000101) only, at offset 0 -> lock with the macro defined; ALIGNED never rises without it.
- **Synchronous reset mid-lock:** rst asserted for 1 cycle while LOCKED -> ALIGNED = 0 and SHIFT = 0 next cycle; relock requires 4 fresh commas.
